ad_capture_ctrl: RTL and testbench
==================================

Name: ad_capture_ctrl

Overview:
Sequences dual-ADC sample capture into the AD1/AD2 FIFOs and services MCU pops from them over the parallel CS/WR_EN/RD_EN/ADDR bus. The MCU writes the capture length and sample divider, then issues start. The block paces FIFO writes, raises the AD1_FLAG/AD2_FLAG done flags, and generates one FIFO read pulse per completed MCU data read. It sits between the ADC front end, the two FIFOs and the bus read-mux that presents FIFO data and flags.

Parameters:
ADDR_CTRL, 16'h0003, control register: bit0 = start, bit1 = abort (write-only, self-clearing)
ADDR_LEN, 16'h0004, capture length in samples, 1..MAX_LEN
ADDR_DIV, 16'h0005, sample divider: one sample every DIV+1 clocks
ADDR_AD1, 16'h0006, AD1 data read address (pop trigger)
ADDR_AD2, 16'h0008, AD2 data read address (pop trigger)
MAX_LEN, 1024, FIFO depth; LEN is clamped to this value

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CS  in  1  bus chip select, active-low, asynchronous to CLK
WR_EN  in  1  bus write strobe, active-high, asynchronous
RD_EN  in  1  bus read strobe, active-high, asynchronous
ADDR  in  16  bus address, stable while the strobe is high
WR_DATA  in  16  bus write data, stable while WR_EN is high
AD1_FIFO_FULL  in  1  AD1 FIFO full
AD2_FIFO_FULL  in  1  AD2 FIFO full
AD1_FIFO_EMPTY  in  1  AD1 FIFO empty
AD2_FIFO_EMPTY  in  1  AD2 FIFO empty
AD1_FIFO_WR_EN  out  1  AD1 FIFO write pulse
AD2_FIFO_WR_EN  out  1  AD2 FIFO write pulse
AD1_FIFO_RD_EN  out  1  AD1 FIFO pop pulse
AD2_FIFO_RD_EN  out  1  AD2 FIFO pop pulse
AD1_FLAG  out  1  AD1 capture complete
AD2_FLAG  out  1  AD2 capture complete
BUSY  out  1  capture in progress

Behaviour:
- Reset:
  - All outputs are 0.
  - LEN = MAX_LEN, DIV = 0, sample count = 0, divider count = 0, state = IDLE.
- Bus synchronisation:
  - CS, WR_EN and RD_EN each pass through a 2-flop synchroniser. ADDR and WR_DATA are sampled without synchronisation.
  - A write is accepted on the synchronised WR_EN rising edge when CS_sync = 0. ADDR and WR_DATA are captured on that cycle.
  - A read completes on the synchronised RD_EN falling edge when CS_sync was 0 at that edge.
  - ADDR is latched on the synchronised RD_EN rising edge.
- Pops:
  - A completed read of ADDR_AD1 drives AD1_FIFO_RD_EN high for exactly 1 CLK. ADDR_AD2 does the same for AD2_FIFO_RD_EN.
  - Pops happen after the read so the MCU sees the current head word.
  - The pop pulse is suppressed when the corresponding FIFO_EMPTY = 1.
- Register writes:
  - ADDR_LEN: LEN = WR_DATA. 0 is stored as 1; values > MAX_LEN are stored as MAX_LEN.
  - ADDR_DIV: DIV = WR_DATA.
  - Writes to LEN or DIV while BUSY = 1 are ignored.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE --start--> CAPTURE. On entry: BUSY = 1, flags cleared, sample count = 0, divider count = 0.
  - CAPTURE: the divider counts 0..DIV. When it equals DIV, both FIFO_WR_EN go high for 1 CLK, sample count increments and the divider returns to 0. With DIV = 0, a write occurs every cycle. The first write occurs DIV+1 cycles after entry.
  - CAPTURE --sample count = LEN after a write--> DONE. In the cycle after the last write: BUSY = 0, AD1_FLAG = AD2_FLAG = 1.
  - DONE --start--> CAPTURE, with flags cleared on entry. Flags otherwise hold in DONE.
  - Abort in any state: go to IDLE, BUSY = 0, flags = 0, no further writes. Abort wins over start if both bits are set.
  - Start while in CAPTURE is ignored.
- Overflow:
  - A write tick with either FIFO_FULL = 1 suppresses both WR_EN, so the two channels stay aligned.
  - The sample count still increments on that tick, so the capture terminates.
- Simultaneous events: bus pops and capture writes are independent and may occur in the same cycle.
- Reset mid-capture returns everything to reset values immediately.

Test Plan:
1. LEN = 8, DIV = 0, start -> 8 consecutive WR_EN pulses on both channels; flags rise 1 CLK after the 8th pulse; BUSY is high for 9 cycles.
2. LEN = 4, DIV = 3, start -> WR_EN pulses every 4 CLK, first at cycle 4; flags set after the 4th pulse.
3. After capture, 4 bus reads of 0x0006 with the FIFO non-empty -> exactly 4 single-cycle AD1_FIFO_RD_EN pulses, each after the RD_EN falling edge; no AD2 pops. Then a read with EMPTY = 1 -> no pulse.
4. LEN = 1000, abort written after 10 writes -> WR_EN stops within 3 CLK of the synchronised write; BUSY = 0, flags = 0. Write LEN = 0 -> next capture yields 1 sample; LEN = 2000 -> 1024 samples.
5. AD2_FIFO_FULL held high during samples 3–5 of LEN = 8 -> no WR_EN on either channel for those ticks; capture still ends after 8 ticks.
6. Assert RST_N low mid-capture -> all outputs 0 asynchronously; after release, LEN = 1024, DIV = 0, state IDLE.

Source files
------------

// File: rtl/ad_capture_ctrl_if.sv
// MCU parallel bus bundle: active-low chip select, write/read strobes, address and write data.
interface ad_capture_ctrl_if;
  logic        CS;
  logic        WR_EN;
  logic        RD_EN;
  logic [15:0] ADDR;
  logic [15:0] WR_DATA;

  modport master (output CS, WR_EN, RD_EN, ADDR, WR_DATA);
  modport slave  (input  CS, WR_EN, RD_EN, ADDR, WR_DATA);
endinterface

// File: rtl/ad_capture_ctrl.sv
// Dual-ADC capture sequencer: paces AD1/AD2 FIFO writes, raises done flags,
// and turns completed MCU data reads into single-cycle FIFO pops.
module ad_capture_ctrl #(
  parameter logic [15:0] ADDR_CTRL = 16'h0003,
  parameter logic [15:0] ADDR_LEN  = 16'h0004,
  parameter logic [15:0] ADDR_DIV  = 16'h0005,
  parameter logic [15:0] ADDR_AD1  = 16'h0006,
  parameter logic [15:0] ADDR_AD2  = 16'h0008,
  parameter int unsigned MAX_LEN   = 1024
) (
  input  logic                CLK,
  input  logic                RST_N,
  ad_capture_ctrl_if.slave    bus,
  input  logic                AD1_FIFO_FULL,
  input  logic                AD2_FIFO_FULL,
  input  logic                AD1_FIFO_EMPTY,
  input  logic                AD2_FIFO_EMPTY,
  output logic                AD1_FIFO_WR_EN,
  output logic                AD2_FIFO_WR_EN,
  output logic                AD1_FIFO_RD_EN,
  output logic                AD2_FIFO_RD_EN,
  output logic                AD1_FLAG,
  output logic                AD2_FLAG,
  output logic                BUSY
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t             state_q, state_d;
  logic               cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
  logic               wr_s1_q, wr_s1_d, wr_s2_q, wr_s2_d, wr_s3_q, wr_s3_d;
  logic               rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d, rd_s3_q, rd_s3_d;
  logic [15:0]        rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        div_q, div_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        div_cnt_q, div_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic               rd1_q, rd1_d;
  logic               rd2_q, rd2_d;
  logic               flag_q, flag_d;
  logic               busy_q, busy_d;

  logic               wr_acc;
  logic               rd_rise;
  logic               rd_done;
  logic               start;
  logic               abort;

  // Next-state logic: bus synchronisers, register file, pop pulses and capture FSM.
  always_comb begin
    state_d   = state_q;
    cs_s1_d   = bus.CS;
    cs_s2_d   = cs_s1_q;
    wr_s1_d   = bus.WR_EN;
    wr_s2_d   = wr_s1_q;
    wr_s3_d   = wr_s2_q;
    rd_s1_d   = bus.RD_EN;
    rd_s2_d   = rd_s1_q;
    rd_s3_d   = rd_s2_q;
    rd_addr_d = rd_addr_q;
    len_d     = len_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    div_cnt_d = div_cnt_q;
    wr_en_d   = 1'b0;
    rd1_d     = 1'b0;
    rd2_d     = 1'b0;
    flag_d    = flag_q;
    busy_d    = busy_q;

    wr_acc  = wr_s2_q & ~wr_s3_q & ~cs_s2_q;
    rd_rise = rd_s2_q & ~rd_s3_q;
    rd_done = ~rd_s2_q & rd_s3_q & ~cs_s2_q;
    start   = wr_acc && (bus.ADDR == ADDR_CTRL) && bus.WR_DATA[0];
    abort   = wr_acc && (bus.ADDR == ADDR_CTRL) && bus.WR_DATA[1];

    if (rd_rise) begin
      rd_addr_d = bus.ADDR;
    end

    // Pop only after the strobe ends so the MCU reads the current head word.
    if (rd_done) begin
      rd1_d = (rd_addr_q == ADDR_AD1) && !AD1_FIFO_EMPTY;
      rd2_d = (rd_addr_q == ADDR_AD2) && !AD2_FIFO_EMPTY;
    end

    if (wr_acc && !busy_q) begin
      if (bus.ADDR == ADDR_LEN) begin
        if (bus.WR_DATA == '0) begin
          len_d = LEN_W'(1);
        end else if (32'(bus.WR_DATA) > MAX_LEN) begin
          len_d = LEN_W'(MAX_LEN);
        end else begin
          len_d = bus.WR_DATA[LEN_W-1:0];
        end
      end
      if (bus.ADDR == ADDR_DIV) begin
        div_d = bus.WR_DATA;
      end
    end

    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      flag_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = CAPTURE;
            busy_d    = 1'b1;
            flag_d    = 1'b0;
            cnt_d     = '0;
            div_cnt_d = '0;
          end
        end
        CAPTURE: begin
          // Completion is checked one cycle after the last tick so the flags
          // appear the cycle after the final write pulse.
          if (cnt_q == len_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            flag_d  = 1'b1;
          end else if (div_cnt_q == div_q) begin
            wr_en_d   = !(AD1_FIFO_FULL || AD2_FIFO_FULL);
            cnt_d     = cnt_q + LEN_W'(1);
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      wr_s1_q   <= 1'b0;
      wr_s2_q   <= 1'b0;
      wr_s3_q   <= 1'b0;
      rd_s1_q   <= 1'b0;
      rd_s2_q   <= 1'b0;
      rd_s3_q   <= 1'b0;
      rd_addr_q <= '0;
      len_q     <= LEN_W'(MAX_LEN);
      div_q     <= '0;
      cnt_q     <= '0;
      div_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      rd1_q     <= 1'b0;
      rd2_q     <= 1'b0;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_s1_q   <= cs_s1_d;
      cs_s2_q   <= cs_s2_d;
      wr_s1_q   <= wr_s1_d;
      wr_s2_q   <= wr_s2_d;
      wr_s3_q   <= wr_s3_d;
      rd_s1_q   <= rd_s1_d;
      rd_s2_q   <= rd_s2_d;
      rd_s3_q   <= rd_s3_d;
      rd_addr_q <= rd_addr_d;
      len_q     <= len_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      div_cnt_q <= div_cnt_d;
      wr_en_q   <= wr_en_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
    end
  end

  assign AD1_FIFO_WR_EN = wr_en_q;
  assign AD2_FIFO_WR_EN = wr_en_q;
  assign AD1_FIFO_RD_EN = rd1_q;
  assign AD2_FIFO_RD_EN = rd2_q;
  assign AD1_FLAG       = flag_q;
  assign AD2_FLAG       = flag_q;
  assign BUSY           = busy_q;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Directed bench for ad_capture_ctrl: capture pacing, flags, pops, clamping, overflow, abort, reset.
module tb_ad_capture_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  logic AD1_FIFO_FULL, AD2_FIFO_FULL, AD1_FIFO_EMPTY, AD2_FIFO_EMPTY;
  logic AD1_FIFO_WR_EN, AD2_FIFO_WR_EN, AD1_FIFO_RD_EN, AD2_FIFO_RD_EN;
  logic AD1_FLAG, AD2_FLAG, BUSY;

  ad_capture_ctrl_if bus ();

  ad_capture_ctrl dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .bus            (bus.slave),
    .AD1_FIFO_FULL  (AD1_FIFO_FULL),
    .AD2_FIFO_FULL  (AD2_FIFO_FULL),
    .AD1_FIFO_EMPTY (AD1_FIFO_EMPTY),
    .AD2_FIFO_EMPTY (AD2_FIFO_EMPTY),
    .AD1_FIFO_WR_EN (AD1_FIFO_WR_EN),
    .AD2_FIFO_WR_EN (AD2_FIFO_WR_EN),
    .AD1_FIFO_RD_EN (AD1_FIFO_RD_EN),
    .AD2_FIFO_RD_EN (AD2_FIFO_RD_EN),
    .AD1_FLAG       (AD1_FLAG),
    .AD2_FLAG       (AD2_FLAG),
    .BUSY           (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Activity monitor, sampled on the falling edge.
  logic mon_clr = 1'b0;
  int cyc = 0;
  int busy_rise, busy_cyc, flag_rise, wr1_cnt, wr2_cnt, misalign;
  int rd1_cnt, rd2_cnt, rd_long, rd_early;
  int wr_cyc [16];
  logic busy_prev, flag_prev, rd1_prev;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (mon_clr) begin
      busy_rise = -1; busy_cyc = 0; flag_rise = -1; wr1_cnt = 0; wr2_cnt = 0;
      misalign = 0; rd1_cnt = 0; rd2_cnt = 0; rd_long = 0; rd_early = 0;
      for (int i = 0; i < 16; i++) wr_cyc[i] = -1;
    end else begin
      if (BUSY && !busy_prev) busy_rise = cyc;
      if (BUSY) busy_cyc = busy_cyc + 1;
      if (AD1_FLAG && !flag_prev) flag_rise = cyc;
      if (AD1_FIFO_WR_EN) begin
        if (wr1_cnt < 16) wr_cyc[wr1_cnt] = cyc;
        wr1_cnt = wr1_cnt + 1;
      end
      if (AD2_FIFO_WR_EN) wr2_cnt = wr2_cnt + 1;
      if (AD1_FIFO_WR_EN !== AD2_FIFO_WR_EN) misalign = misalign + 1;
      if (AD1_FIFO_RD_EN) begin
        rd1_cnt = rd1_cnt + 1;
        if (rd1_prev) rd_long = rd_long + 1;
        if (bus.RD_EN) rd_early = rd_early + 1;
      end
      if (AD2_FIFO_RD_EN) rd2_cnt = rd2_cnt + 1;
    end
    busy_prev = BUSY;
    flag_prev = AD1_FLAG;
    rd1_prev  = AD1_FIFO_RD_EN;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge CLK);
    #1 mon_clr = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge CLK);
    bus.ADDR = a; bus.WR_DATA = d; bus.CS = 1'b0;
    repeat (2) @(negedge CLK);
    bus.WR_EN = 1'b1;
    repeat (4) @(negedge CLK);
    bus.WR_EN = 1'b0;
    repeat (3) @(negedge CLK);
    bus.CS = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic bus_read(input logic [15:0] a);
    @(negedge CLK);
    bus.ADDR = a; bus.CS = 1'b0;
    repeat (2) @(negedge CLK);
    bus.RD_EN = 1'b1;
    repeat (4) @(negedge CLK);
    bus.RD_EN = 1'b0;
    repeat (4) @(negedge CLK);
    bus.CS = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_flag(input string tag, input int limit);
    int n = 0;
    while (!AD1_FLAG && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check(tag, AD1_FLAG, 1);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_busy(input int limit);
    int n = 0;
    while (!BUSY && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check("busy_seen", BUSY, 1);
  endtask

  int snap;

  initial begin
    RST_N = 1'b0;
    bus.CS = 1'b1; bus.WR_EN = 1'b0; bus.RD_EN = 1'b0; bus.ADDR = '0; bus.WR_DATA = '0;
    AD1_FIFO_FULL = 1'b0; AD2_FIFO_FULL = 1'b0; AD1_FIFO_EMPTY = 1'b0; AD2_FIFO_EMPTY = 1'b0;
    #1;
    check("rst_outs", {AD1_FIFO_WR_EN, AD2_FIFO_WR_EN, AD1_FIFO_RD_EN, AD2_FIFO_RD_EN,
                       AD1_FLAG, AD2_FLAG, BUSY}, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    clr_mon();

    // 1: LEN=8 DIV=0
    bus_write(16'h0004, 16'd8);
    bus_write(16'h0005, 16'd0);
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    wait_flag("t1_done", 100);
    check("t1_wr1", wr1_cnt, 8);
    check("t1_wr2", wr2_cnt, 8);
    check("t1_first", wr_cyc[0] - busy_rise, 1);
    check("t1_last", wr_cyc[7] - busy_rise, 8);
    check("t1_busy", busy_cyc, 9);
    check("t1_flag", flag_rise - busy_rise, 9);
    check("t1_flag2", AD2_FLAG, 1);
    check("t1_align", misalign, 0);

    // 2: LEN=4 DIV=3
    bus_write(16'h0004, 16'd4);
    bus_write(16'h0005, 16'd3);
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    wait_flag("t2_done", 100);
    check("t2_wr1", wr1_cnt, 4);
    check("t2_p0", wr_cyc[0] - busy_rise, 4);
    check("t2_p1", wr_cyc[1] - busy_rise, 8);
    check("t2_p3", wr_cyc[3] - busy_rise, 16);
    check("t2_flag", flag_rise - busy_rise, 17);
    check("t2_busy", busy_cyc, 17);

    // 3: pops
    clr_mon();
    for (int i = 0; i < 4; i++) bus_read(16'h0006);
    check("t3_rd1", rd1_cnt, 4);
    check("t3_width", rd_long, 0);
    check("t3_early", rd_early, 0);
    check("t3_rd2", rd2_cnt, 0);
    check("t3_flag_hold", AD1_FLAG, 1);
    AD1_FIFO_EMPTY = 1'b1;
    clr_mon();
    bus_read(16'h0006);
    check("t3_empty", rd1_cnt, 0);
    AD1_FIFO_EMPTY = 1'b0;
    clr_mon();
    bus_read(16'h0008);
    check("t3_ad2_rd2", rd2_cnt, 1);
    check("t3_ad2_rd1", rd1_cnt, 0);

    // 4: abort, then LEN clamping
    bus_write(16'h0004, 16'd1000);
    bus_write(16'h0005, 16'd0);
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    snap = 0;
    while (wr1_cnt < 10 && snap < 100) begin
      @(negedge CLK);
      snap++;
    end
    check("t4_reach10", wr1_cnt >= 10, 1);
    bus_write(16'h0003, 16'h0003);
    snap = wr1_cnt;
    repeat (20) @(negedge CLK);
    check("t4_stopped", wr1_cnt, snap);
    check("t4_bounded", wr1_cnt <= 25, 1);
    check("t4_busy", BUSY, 0);
    check("t4_flag", AD1_FLAG, 0);
    bus_write(16'h0004, 16'd0);
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    wait_flag("t4_len0_done", 100);
    check("t4_len0", wr1_cnt, 1);
    bus_write(16'h0004, 16'd2000);
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    wait_flag("t4_len2000_done", 1200);
    check("t4_len2000", wr1_cnt, 1024);

    // LEN write while busy is ignored
    bus_write(16'h0004, 16'd8);
    bus_write(16'h0005, 16'd3);
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    bus_write(16'h0004, 16'd2);
    wait_flag("tb_ign_done", 100);
    check("t_busy_ign", wr1_cnt, 8);

    // 5: AD2 full over ticks 3..5 (LEN=8, DIV=3: tick k decided in cycle busy_rise+4k-1)
    clr_mon();
    fork
      bus_write(16'h0003, 16'h0001);
      begin
        wait_busy(50);
        repeat (9) @(negedge CLK);
        AD2_FIFO_FULL = 1'b1;
        repeat (11) @(negedge CLK);
        AD2_FIFO_FULL = 1'b0;
      end
    join
    wait_flag("t5_done", 100);
    check("t5_wr1", wr1_cnt, 5);
    check("t5_wr2", wr2_cnt, 5);
    check("t5_p2", wr_cyc[2] - busy_rise, 24);
    check("t5_flag", flag_rise - busy_rise, 33);
    check("t5_align", misalign, 0);

    // 6: asynchronous reset mid-capture, then reset LEN/DIV values
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    repeat (4) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("t6_outs", {AD1_FIFO_WR_EN, AD2_FIFO_WR_EN, AD1_FIFO_RD_EN, AD2_FIFO_RD_EN,
                      AD1_FLAG, AD2_FLAG, BUSY}, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    check("t6_idle", BUSY, 0);
    clr_mon();
    bus_write(16'h0003, 16'h0001);
    wait_flag("t6_done", 1200);
    check("t6_len", wr1_cnt, 1024);
    check("t6_busy", busy_cyc, 1025);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
